// File: rtl/md_hilo_unit.sv
// rtl/md_hilo_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU, opcodes 9-12) enabled by macro MD_HILO_MADD_EN.
module md_hilo_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
`ifdef MD_HILO_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_sh_hi;
    logic [WIDTH-1:0]   r_sh_lo;
    logic               r_sh_wr;

    state_t             w_state_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [WIDTH-1:0]   w_hi_nx;
    logic [WIDTH-1:0]   w_lo_nx;
    logic [WIDTH-1:0]   w_sh_hi_nx;
    logic [WIDTH-1:0]   w_sh_lo_nx;
    logic               w_sh_wr_nx;

    logic [2*WIDTH-1:0] w_sa_ext;
    logic [2*WIDTH-1:0] w_sb_ext;
    logic [2*WIDTH-1:0] w_ua_ext;
    logic [2*WIDTH-1:0] w_ub_ext;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_den_s;
    logic [WIDTH-1:0]   w_den_u;
    logic [WIDTH-1:0]   w_uq_s;
    logic [WIDTH-1:0]   w_ur_s;
    logic [WIDTH-1:0]   w_q_s;
    logic [WIDTH-1:0]   w_r_s;
    logic [WIDTH-1:0]   w_q_u;
    logic [WIDTH-1:0]   w_r_u;
`ifdef MD_HILO_MADD_EN
    logic [2*WIDTH-1:0] w_acc;
`endif

    // Results computed from the operands present on the start edge.
    // Signed products come from multiplying sign-extended operands; the low
    // 2*WIDTH bits are the exact signed product. Signed division works on
    // magnitudes: most-negative / -1 then naturally yields lo=most-negative, hi=0.
    // A zero divisor is replaced by 1 only to keep the divider defined; the
    // result is discarded in that case.
    always_comb begin
        w_sa_ext = {{WIDTH{a[WIDTH-1]}}, a};
        w_sb_ext = {{WIDTH{b[WIDTH-1]}}, b};
        w_ua_ext = {{WIDTH{1'b0}}, a};
        w_ub_ext = {{WIDTH{1'b0}}, b};
        w_prod_s = w_sa_ext * w_sb_ext;
        w_prod_u = w_ua_ext * w_ub_ext;
        w_a_neg  = a[WIDTH-1];
        w_b_neg  = b[WIDTH-1];
        w_b_zero = (b == '0);
        w_a_mag  = w_a_neg ? -a : a;
        w_b_mag  = w_b_neg ? -b : b;
        w_den_s  = w_b_zero ? WIDTH'(1) : w_b_mag;
        w_den_u  = w_b_zero ? WIDTH'(1) : b;
        w_uq_s   = w_a_mag / w_den_s;
        w_ur_s   = w_a_mag % w_den_s;
        w_q_s    = (w_a_neg ^ w_b_neg) ? -w_uq_s : w_uq_s;
        w_r_s    = w_a_neg ? -w_ur_s : w_ur_s;
        w_q_u    = a / w_den_u;
        w_r_u    = a % w_den_u;
    end

`ifdef MD_HILO_MADD_EN
    // Accumulate base is HI/LO as they stand on the start edge.
    assign w_acc = {r_hi, r_lo};
`endif

    // Next-state: launch ops from IDLE, count down in RUN, commit on the last edge.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        w_sh_hi_nx = r_sh_hi;
        w_sh_lo_nx = r_sh_lo;
        w_sh_wr_nx = r_sh_wr;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            {w_sh_hi_nx, w_sh_lo_nx} = w_prod_s;
                            w_sh_wr_nx = 1'b1;
                            w_cnt_nx   = MULT_CNT;
                            w_state_nx = S_RUN;
                        end
                        OP_MULTU: begin
                            {w_sh_hi_nx, w_sh_lo_nx} = w_prod_u;
                            w_sh_wr_nx = 1'b1;
                            w_cnt_nx   = MULT_CNT;
                            w_state_nx = S_RUN;
                        end
                        OP_DIV: begin
                            w_sh_hi_nx = w_r_s;
                            w_sh_lo_nx = w_q_s;
                            w_sh_wr_nx = !w_b_zero;
                            w_cnt_nx   = DIV_CNT;
                            w_state_nx = S_RUN;
                        end
                        OP_DIVU: begin
                            w_sh_hi_nx = w_r_u;
                            w_sh_lo_nx = w_q_u;
                            w_sh_wr_nx = !w_b_zero;
                            w_cnt_nx   = DIV_CNT;
                            w_state_nx = S_RUN;
                        end
                        OP_MTHI: w_hi_nx = a;
                        OP_MTLO: w_lo_nx = a;
`ifdef MD_HILO_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            case (op)
                                OP_MADD:  {w_sh_hi_nx, w_sh_lo_nx} = w_acc + w_prod_s;
                                OP_MADDU: {w_sh_hi_nx, w_sh_lo_nx} = w_acc + w_prod_u;
                                OP_MSUB:  {w_sh_hi_nx, w_sh_lo_nx} = w_acc - w_prod_s;
                                default:  {w_sh_hi_nx, w_sh_lo_nx} = w_acc - w_prod_u;
                            endcase
                            w_sh_wr_nx = 1'b1;
                            w_cnt_nx   = MULT_CNT;
                            w_state_nx = S_RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: begin
                w_cnt_nx = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nx = S_IDLE;
                    if (r_sh_wr) begin
                        w_hi_nx = r_sh_hi;
                        w_lo_nx = r_sh_lo;
                    end
                end
            end
        endcase
    end

    // State register; reset cancels any op in flight and clears HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_sh_hi <= '0;
            r_sh_lo <= '0;
            r_sh_wr <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            r_sh_hi <= w_sh_hi_nx;
            r_sh_lo <= w_sh_lo_nx;
            r_sh_wr <= w_sh_wr_nx;
        end
    end

    assign busy  = (r_state == S_RUN);
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign rdata = (op == OP_MFHI) ? r_hi : r_lo;

endmodule

// File: tb/tb_md_hilo_unit.sv
// tb/tb_md_hilo_unit.sv - scoreboard bench for md_hilo_unit with a behavioural HI/LO model
module tb_md_hilo_unit;

    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    md_hilo_unit #(.WIDTH(32), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .rdata (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic        tb_sync = 1'b0;
    logic        busy_q = 1'b0;
    int          run_len = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Architectural model: plain 64-bit arithmetic on the HI/LO pair.
    function automatic int model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] p;
        int          lat;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'h0, x};
        uy  = {32'h0, y};
        lat = 0;
        case (o)
            4'd1: begin p = sx * sy; {m_hi, m_lo} = p; lat = ML; end
            4'd2: begin p = ux * uy; {m_hi, m_lo} = p; lat = ML; end
            4'd3: begin
                lat = DL;
                if (y != 0) begin
                    q = sx / sy;
                    r = sx % sy;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            4'd4: begin
                lat = DL;
                if (y != 0) begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
            4'd5: m_hi = x;
            4'd6: m_lo = x;
`ifdef MD_HILO_MADD_EN
            4'd9:  begin p = sx * sy; {m_hi, m_lo} = {m_hi, m_lo} + p; lat = ML; end
            4'd10: begin p = ux * uy; {m_hi, m_lo} = {m_hi, m_lo} + p; lat = ML; end
            4'd11: begin p = sx * sy; {m_hi, m_lo} = {m_hi, m_lo} - p; lat = ML; end
            4'd12: begin p = ux * uy; {m_hi, m_lo} = {m_hi, m_lo} - p; lat = ML; end
`endif
            default: ;
        endcase
        return lat;
    endfunction

    task automatic sync_check(input exp_t e);
        expq.push_back(e);
        tb_sync = 1'b1;
        @(posedge clk); #1;
        tb_sync = 1'b0;
    endtask

    // Issue one op; optionally fire an illegal start while busy (must be ignored).
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input bit inj);
        int   lat;
        int   n;
        exp_t e;
        lat   = model(o, x, y);
        e.lat = lat;
        e.hi  = m_hi;
        e.lo  = m_lo;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        op = ($urandom_range(0, 1) != 0) ? 4'd7 : 4'd8;
        if (lat == 0) begin
            sync_check(e);
        end else begin
            expq.push_back(e);
            n = 0;
            while (busy && n < lat + 4) begin
                if (inj && n == 2) begin
                    start = 1'b1; op = 4'd6; a = 32'h55; b = $urandom;
                end
                @(posedge clk); #1;
                start = 1'b0;
                n++;
            end
            if (busy) begin
                checks++;
                errors++;
                $display("FAIL busy_timeout actual=busy_after_%0d expected=idle", n);
            end
        end
    endtask

    // Monitor: pops an expectation when busy falls or the stimulus requests a sync point.
    always @(negedge clk) begin
        if (busy === 1'b1) run_len++;
        if ((busy_q === 1'b1 && busy === 1'b0) || tb_sync) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL queue_underflow actual=empty expected=entry");
            end else begin
                mon_e = expq.pop_front();
                checki("busy_len", run_len, mon_e.lat);
                check32("busy_low", {31'h0, busy}, 32'h0);
                check32("hi", hi, mon_e.hi);
                check32("lo", lo, mon_e.lo);
                check32("rdata", rdata, (op == 4'd7) ? mon_e.hi : mon_e.lo);
            end
            run_len = 0;
        end
        busy_q = busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        exp_t        e;
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0;
        e = '{0, 32'h0, 32'h0};
        sync_check(e);

        // Directed plan items, with literal expectations alongside the scoreboard.
        issue(4'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0);
        check32("t1_hi", hi, 32'hFFFFFFFF);
        check32("t1_lo", lo, 32'hFFFFFFFE);
        issue(4'd2, 32'hFFFFFFFF, 32'h00000002, 1'b0);
        check32("t2_hi", hi, 32'h00000001);
        check32("t2_lo", lo, 32'hFFFFFFFE);
        issue(4'd3, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        check32("t3_hi", hi, 32'hFFFFFFFF);
        check32("t3_lo", lo, 32'hFFFFFFFD);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check32("t3_ovf_hi", hi, 32'h00000000);
        check32("t3_ovf_lo", lo, 32'h80000000);
        issue(4'd5, 32'h12345678, 32'h0, 1'b0);
        issue(4'd4, 32'h00000007, 32'h0, 1'b1);
        check32("t4_hi", hi, 32'h12345678);
        check32("t4_lo", lo, 32'h80000000);

        // Reset during a divide: result never commits.
        m_hi = 32'h0; m_lo = 32'h0;
        e = '{4, 32'h0, 32'h0};
        expq.push_back(e);
        start = 1'b1; op = 4'd4; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (DL + 2) begin @(posedge clk); #1; end
        check32("t5_hi_stays0", hi, 32'h0);
        check32("t5_lo_stays0", lo, 32'h0);

        // Reset wins over a simultaneous start.
        issue(4'd5, 32'hCAFEF00D, 32'h0, 1'b0);
        start = 1'b1; op = 4'd6; a = 32'hABCD1234; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0;
        e = '{0, 32'h0, 32'h0};
        sync_check(e);

        // Accumulate op (NOP when the feature is not built).
        issue(4'd5, 32'h0, 32'h0, 1'b0);
        issue(4'd6, 32'hFFFFFFFF, 32'h0, 1'b0);
        issue(4'd10, 32'h1, 32'h1, 1'b0);
`ifdef MD_HILO_MADD_EN
        check32("t6_hi", hi, 32'h1);
        check32("t6_lo", lo, 32'h0);
`else
        check32("t6_hi", hi, 32'h0);
        check32("t6_lo", lo, 32'hFFFFFFFF);
`endif

        // Randomised ops with boundary operands mixed in.
        for (int i = 0; i < 80; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: begin x = $urandom_range(0, 200); y = $urandom_range(1, 15); end
                3: y = 32'h0 - 32'($urandom_range(1, 9));
                default: ;
            endcase
            issue(o, x, y, ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(posedge clk);
        #1;
        checki("queue_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
